key_event_sequencer: RTL and testbench
======================================

KEY_EVENT_SEQUENCER -- requirements
Module: key_event_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: event FIFO entries, power of two, range 2..16.
REQ-002 Parameter SUPPRESS_REPEAT, default 1: 1 drops typematic repeat makes of the held key; 0 passes them through.
REQ-003 PS2Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 byte_in  input  8  received scancode byte from the PS/2 byte receiver.
REQ-006 byte_valid  input  1  one-cycle strobe; byte_in is valid in that cycle.
REQ-007 byte_err  input  1  qualifies byte_valid; 1 means parity or stop-bit failure.
REQ-008 ev_code  output  8  scancode of the event at the FIFO head.
REQ-009 ev_break  output  1  head event is a release (1) or a press (0).
REQ-010 ev_ext  output  1  head event carried an E0 prefix.
REQ-011 ev_valid  output  1  FIFO non-empty; head fields are valid.
REQ-012 ev_ready  input  1  consumer accepts the head when ev_valid&&ev_ready.
REQ-013 key_held  output  1  a non-released key press is tracked.
REQ-014 held_code  output  9  {ext,code} of the tracked key.
REQ-015 ovf  output  1  sticky; an event was dropped because the FIFO was full.
REQ-016 rx_err  output  1  sticky; a byte arrived with byte_err=1.
REQ-017 flag_clr  input  1  synchronous clear of ovf and rx_err.

Function
REQ-018 Decoder FSM states: IDLE, PFX_E0, PFX_F0, PFX_E0F0; it advances only on byte_valid cycles.
REQ-019 From IDLE: 0xE0 goes to PFX_E0; 0xF0 goes to PFX_F0; any other byte yields a make event {ext=0} and returns to IDLE.
REQ-020 From PFX_E0: 0xF0 goes to PFX_E0F0; 0xE0 stays in PFX_E0; any other byte yields a make event {ext=1} and goes to IDLE.
REQ-021 From PFX_F0: any byte other than 0xE0/0xF0 yields a break event {ext=0} and goes to IDLE; 0xE0 or 0xF0 goes to IDLE and emits nothing.
REQ-022 From PFX_E0F0: any byte other than 0xE0/0xF0 yields a break event {ext=1} and goes to IDLE; 0xE0 or 0xF0 goes to IDLE and emits nothing.
REQ-023 byte_valid with byte_err=1 returns the FSM to IDLE, emits nothing, and sets rx_err.
REQ-024 Make event: if SUPPRESS_REPEAT=1, key_held=1 and {ext,code}==held_code, drop it (typematic repeat); otherwise push it, set key_held, and load held_code.
REQ-025 Break event: always push it; if it matches held_code, clear key_held; a non-matching break leaves key_held and held_code unchanged.
REQ-026 Latency: a pushed event is visible on ev_valid/ev_* in the cycle after the byte_valid of its final byte.
REQ-027 FIFO is first-word-fall-through; ev_* hold stable while ev_valid&&!ev_ready.
REQ-028 Push when full and no pop in the same cycle: drop the event and set ovf; FIFO contents are unchanged.
REQ-029 Push and pop in the same cycle when full: both succeed; occupancy stays FIFO_DEPTH and ovf is unchanged.
REQ-030 Push and pop in the same cycle when empty: push succeeds; ev_valid=1 next cycle.
REQ-031 Pop when empty is ignored.
REQ-032 Read and write pointers wrap modulo FIFO_DEPTH; the occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
REQ-033 flag_clr and a same-cycle setting event: the set wins.
REQ-034 held_code tracking is updated even when the event is dropped by overflow.

Reset
REQ-035 rstn=0 asynchronously sets: FSM=IDLE, FIFO empty, ev_valid=0, ev_code=0x00, ev_break=0, ev_ext=0, key_held=0, held_code=0, ovf=0, rx_err=0.
REQ-036 Reset asserted mid-sequence (e.g. after F0) discards the pending prefix; the first post-reset byte is decoded from IDLE.
REQ-037 Outputs are registered; no combinational path runs from byte_in to ev_*.

Verification
REQ-038 Bytes 0x17,0x17,0x17,F0,0x17 with ev_ready=1 -> exactly two events: make 0x17, then break 0x17; key_held=1 after the first byte and 0 after the last.
REQ-039 Same stimulus with SUPPRESS_REPEAT=0 -> three make 0x17 events, then one break 0x17.
REQ-040 Bytes E0,0x75,E0,F0,0x75 -> make {ext=1,0x75}, then break {ext=1,0x75}; held_code=0x175 in between.
REQ-041 ev_ready=0 with six distinct makes at FIFO_DEPTH=4 -> four entries retained in order, ovf=1; after flag_clr, ovf=0.
REQ-042 F0 followed by 0x16 with byte_err=1 -> no event, rx_err=1; a following 0x16 -> make 0x16.
REQ-043 rstn pulsed low after F0, then 0x16 -> make 0x16, not a break; all outputs at their reset values during reset.

Source files
------------

// File: rtl/key_event_sequencer.sv
// PS/2 scancode decoder: folds E0/F0 prefixes into make/break events, tracks the
// currently held key, and queues events in a first-word-fall-through FIFO.
module key_event_sequencer #(
  parameter int FIFO_DEPTH      = 4,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       PS2Clk,
  input  logic       rstn,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_err,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       key_held,
  output logic [8:0] held_code,
  output logic       ovf,
  output logic       rx_err,
  input  logic       flag_clr
);

  localparam int            AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PFX_E0, PFX_F0, PFX_E0F0} state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  state_e        state_q, state_d;
  logic          dec_vld;
  event_t        dec_ev;
  logic          is_pfx;
  logic          good_byte;

  assign is_pfx    = (byte_in == 8'hE0) || (byte_in == 8'hF0);
  assign good_byte = byte_valid && !byte_err;

  // ---------------- decoder FSM ----------------
  always_ff @(posedge PS2Clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (byte_valid) begin
      if (byte_err) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE:    state_d = (byte_in == 8'hE0) ? PFX_E0 :
                             (byte_in == 8'hF0) ? PFX_F0 : IDLE;
          PFX_E0:  state_d = (byte_in == 8'hF0) ? PFX_E0F0 :
                             (byte_in == 8'hE0) ? PFX_E0 : IDLE;
          PFX_F0,
          PFX_E0F0: state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // A non-prefix byte always terminates a sequence; the state says which kind.
  always_comb begin
    dec_vld     = good_byte && !is_pfx;
    dec_ev.code = byte_in;
    dec_ev.ext  = (state_q == PFX_E0) || (state_q == PFX_E0F0);
    dec_ev.brk  = (state_q == PFX_F0) || (state_q == PFX_E0F0);
  end

  // ---------------- held-key tracking ----------------
  logic       key_held_q, key_held_d;
  logic [8:0] held_code_q, held_code_d;
  logic       push;
  logic [8:0] dec_key;

  assign dec_key = {dec_ev.ext, dec_ev.code};

  always_comb begin
    push        = 1'b0;
    key_held_d  = key_held_q;
    held_code_d = held_code_q;
    if (dec_vld) begin
      if (!dec_ev.brk) begin
        if (!(SUPPRESS_REPEAT && key_held_q && (dec_key == held_code_q))) begin
          push        = 1'b1;
          key_held_d  = 1'b1;
          held_code_d = dec_key;
        end
      end else begin
        push = 1'b1;
        if (dec_key == held_code_q) key_held_d = 1'b0;
      end
    end
  end

  always_ff @(posedge PS2Clk or negedge rstn) begin
    if (!rstn) begin
      key_held_q  <= 1'b0;
      held_code_q <= '0;
    end else begin
      key_held_q  <= key_held_d;
      held_code_q <= held_code_d;
    end
  end

  // ---------------- event FIFO ----------------
  event_t        mem_q [FIFO_DEPTH];
  event_t        mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop, full, wr_en, drop;
  logic          ovf_q, ovf_d, rx_err_q, rx_err_d;

  assign pop   = (count_q != '0) && ev_ready;
  assign full  = (count_q == DEPTH);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = dec_ev;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
  end

  // Setting events take priority over flag_clr.
  always_comb begin
    ovf_d    = drop ? 1'b1 : (flag_clr ? 1'b0 : ovf_q);
    rx_err_d = (byte_valid && byte_err) ? 1'b1 : (flag_clr ? 1'b0 : rx_err_q);
  end

  always_ff @(posedge PS2Clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rx_err_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rx_err_q <= rx_err_d;
    end
  end

  // Head fields are zeroed while empty so stale entries never leak out.
  event_t head;
  assign head      = mem_q[rd_ptr_q];
  assign ev_valid  = (count_q != '0);
  assign ev_code   = ev_valid ? head.code : 8'h00;
  assign ev_break  = ev_valid & head.brk;
  assign ev_ext    = ev_valid & head.ext;
  assign key_held  = key_held_q;
  assign held_code = held_code_q;
  assign ovf       = ovf_q;
  assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_key_event_sequencer.sv
// Bench: two sequencers (repeat suppression on/off) share stimulus; directed
// tables, hand sequences and random traffic are checked against a queue model.
module tb_key_event_sequencer;
  localparam int DEPTH = 4;

  logic       PS2Clk = 1'b0;
  logic       rstn;
  logic [7:0] byte_in;
  logic       byte_valid, byte_err, ev_ready, flag_clr;

  logic [7:0] ev_code_a  [2];
  logic       ev_break_a [2];
  logic       ev_ext_a   [2];
  logic       ev_valid_a [2];
  logic       key_held_a [2];
  logic [8:0] held_code_a[2];
  logic       ovf_a      [2];
  logic       rx_err_a   [2];

  int nvec = 0;
  int nmis = 0;

  always #5 PS2Clk = ~PS2Clk;

  key_event_sequencer #(.FIFO_DEPTH(DEPTH), .SUPPRESS_REPEAT(1'b1)) u_sup (
    .PS2Clk(PS2Clk), .rstn(rstn), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_err(byte_err), .ev_code(ev_code_a[0]), .ev_break(ev_break_a[0]),
    .ev_ext(ev_ext_a[0]), .ev_valid(ev_valid_a[0]), .ev_ready(ev_ready),
    .key_held(key_held_a[0]), .held_code(held_code_a[0]), .ovf(ovf_a[0]),
    .rx_err(rx_err_a[0]), .flag_clr(flag_clr));

  key_event_sequencer #(.FIFO_DEPTH(DEPTH), .SUPPRESS_REPEAT(1'b0)) u_rep (
    .PS2Clk(PS2Clk), .rstn(rstn), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_err(byte_err), .ev_code(ev_code_a[1]), .ev_break(ev_break_a[1]),
    .ev_ext(ev_ext_a[1]), .ev_valid(ev_valid_a[1]), .ev_ready(ev_ready),
    .key_held(key_held_a[1]), .held_code(held_code_a[1]), .ovf(ovf_a[1]),
    .rx_err(rx_err_a[1]), .flag_clr(flag_clr));

  // ---------------- reference model ----------------
  logic       m_pe0[2], m_pf0[2], m_held[2], m_ovf[2], m_rx[2];
  logic [8:0] m_hc[2];
  logic [9:0] mq[2][$];   // {ext, brk, code}

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pe0[i] = 0; m_pf0[i] = 0; m_held[i] = 0; m_ovf[i] = 0; m_rx[i] = 0;
      m_hc[i] = '0; mq[i].delete();
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic pop, ev, ext, brk, push, drop;
      logic [8:0] key;
      logic [9:0] tmp;
      if (rstn) begin
        pop = ev_ready && (mq[i].size() != 0);
        ev = 0; ext = m_pe0[i]; brk = m_pf0[i];
        if (byte_valid) begin
          if (byte_err) begin
            m_pe0[i] = 0; m_pf0[i] = 0;
          end else if (byte_in == 8'hE0 || byte_in == 8'hF0) begin
            if (m_pf0[i]) begin m_pe0[i] = 0; m_pf0[i] = 0; end
            else if (byte_in == 8'hE0) m_pe0[i] = 1;
            else m_pf0[i] = 1;
          end else begin
            ev = 1; m_pe0[i] = 0; m_pf0[i] = 0;
          end
        end
        key = {ext, byte_in};
        push = 0;
        if (ev) begin
          if (!brk) begin
            if (!(i == 0 && m_held[i] && key == m_hc[i])) begin
              push = 1; m_held[i] = 1; m_hc[i] = key;
            end
          end else begin
            push = 1;
            if (key == m_hc[i]) m_held[i] = 0;
          end
        end
        drop = push && (mq[i].size() == DEPTH) && !pop;
        if (pop) tmp = mq[i].pop_front();
        if (push && !drop) mq[i].push_back({ext, brk, byte_in});
        m_ovf[i] = drop ? 1'b1 : (flag_clr ? 1'b0 : m_ovf[i]);
        m_rx[i]  = (byte_valid && byte_err) ? 1'b1 : (flag_clr ? 1'b0 : m_rx[i]);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      logic       ev;
      logic [9:0] eh, ah;
      ev = (mq[i].size() != 0);
      eh = ev ? mq[i][0] : 10'h0;
      ah = ev_valid_a[i] ? {ev_ext_a[i], ev_break_a[i], ev_code_a[i]} : 10'h0;
      check(i == 0 ? "model_sup" : "model_rep",
            {9'h0, ev_valid_a[i], ah, key_held_a[i], held_code_a[i], ovf_a[i], rx_err_a[i]},
            {9'h0, ev, eh, m_held[i], m_hc[i], m_ovf[i], m_rx[i]});
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge PS2Clk); #1;
    check_model();
  endtask

  task automatic send(input logic [7:0] b, input logic err);
    byte_in = b; byte_valid = 1; byte_err = err;
    tick();
    byte_valid = 0; byte_err = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    for (int i = 0; i < 2; i++)
      check(name, {8'h0, ev_code_a[i], ev_break_a[i], ev_ext_a[i], ev_valid_a[i],
                   key_held_a[i], held_code_a[i], ovf_a[i], rx_err_a[i]}, 32'h0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] b;
    logic       v;
    logic       exp_v;
    logic [7:0] exp_code;
    logic       exp_brk;
    logic       exp_ext;
    logic       exp_held;
    logic [8:0] exp_hc;
  } vec_t;

  vec_t       tbl[12];
  logic [7:0] pool[8];
  logic [7:0] six[6];

  initial begin
    int nmake;
    tbl[0]  = '{8'h17, 1, 1, 8'h17, 0, 0, 1, 9'h017};
    tbl[1]  = '{8'h17, 1, 0, 8'h00, 0, 0, 1, 9'h017};
    tbl[2]  = '{8'h17, 1, 0, 8'h00, 0, 0, 1, 9'h017};
    tbl[3]  = '{8'hF0, 1, 0, 8'h00, 0, 0, 1, 9'h017};
    tbl[4]  = '{8'h17, 1, 1, 8'h17, 1, 0, 0, 9'h017};
    tbl[5]  = '{8'h00, 0, 0, 8'h00, 0, 0, 0, 9'h017};
    tbl[6]  = '{8'hE0, 1, 0, 8'h00, 0, 0, 0, 9'h017};
    tbl[7]  = '{8'h75, 1, 1, 8'h75, 0, 1, 1, 9'h175};
    tbl[8]  = '{8'hE0, 1, 0, 8'h00, 0, 0, 1, 9'h175};
    tbl[9]  = '{8'hF0, 1, 0, 8'h00, 0, 0, 1, 9'h175};
    tbl[10] = '{8'h75, 1, 1, 8'h75, 1, 1, 0, 9'h175};
    tbl[11] = '{8'h00, 0, 0, 8'h00, 0, 0, 0, 9'h175};
    pool = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h16, 8'h17, 8'h1C, 8'h75};
    six  = '{8'h15, 8'h16, 8'h1C, 8'h1D, 8'h24, 8'h2D};

    rstn = 0; byte_in = 0; byte_valid = 0; byte_err = 0; ev_ready = 1; flag_clr = 0;
    model_reset();
    #12;
    check_reset_outputs("reset_init");
    rstn = 1;
    @(posedge PS2Clk); #1;

    // Make / repeat / break, then extended make / break.
    nmake = 0;
    for (int k = 0; k < 12; k++) begin
      byte_in = tbl[k].b; byte_valid = tbl[k].v;
      tick();
      byte_valid = 0;
      check($sformatf("tbl%0d", k),
            {ev_valid_a[0], ev_valid_a[0] ? {ev_code_a[0], ev_break_a[0], ev_ext_a[0]} : 10'h0,
             key_held_a[0], held_code_a[0]},
            {tbl[k].exp_v, tbl[k].exp_code, tbl[k].exp_brk, tbl[k].exp_ext,
             tbl[k].exp_held, tbl[k].exp_hc});
      if (k < 5 && ev_valid_a[1] && !ev_break_a[1] && ev_code_a[1] == 8'h17) nmake++;
    end
    check("rep_make_count", nmake, 3);

    // Overflow with a stalled consumer; held_code still follows dropped makes.
    ev_ready = 0;
    for (int k = 0; k < 6; k++) send(six[k], 0);
    check("ovf_set", {ovf_a[0], ovf_a[1]}, 2'b11);
    check("held_after_drop", {key_held_a[0], held_code_a[0]}, {1'b1, 9'h02D});
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d", k), {ev_valid_a[0], ev_code_a[0]}, {1'b1, six[k]});
      ev_ready = 1; tick(); ev_ready = 0;
    end
    check("drained", ev_valid_a[0], 1'b0);
    flag_clr = 1; tick(); flag_clr = 0;
    check("ovf_clr", ovf_a[0], 1'b0);

    // Errored byte after F0 aborts the break.
    ev_ready = 1;
    send(8'hF0, 0);
    send(8'h16, 1);
    check("err_no_event", {ev_valid_a[0], rx_err_a[0]}, 2'b01);
    send(8'h16, 0);
    check("err_then_make", {ev_valid_a[0], ev_break_a[0], ev_ext_a[0], ev_code_a[0]},
          {3'b100, 8'h16});
    flag_clr = 1; byte_in = 8'h55; byte_valid = 1; byte_err = 1;
    tick();
    flag_clr = 0; byte_valid = 0; byte_err = 0;
    check("set_beats_clr", rx_err_a[0], 1'b1);
    flag_clr = 1; tick(); flag_clr = 0;

    // Reset in the middle of a break prefix.
    ev_ready = 0;
    send(8'h1C, 0);
    send(8'hF0, 0);
    rstn = 0; #1;
    check_reset_outputs("reset_mid");
    model_reset();
    #2 rstn = 1;
    send(8'h16, 0);
    check("post_reset_make", {ev_valid_a[0], ev_break_a[0], ev_ext_a[0], ev_code_a[0]},
          {3'b100, 8'h16});

    // Random traffic; second half stalls the consumer more to exercise overflow.
    for (int n = 0; n < 1200; n++) begin
      byte_valid = ($urandom_range(0, 1) == 1);
      byte_in    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      byte_err   = ($urandom_range(0, 15) == 0);
      ev_ready   = (n < 600) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
      flag_clr   = ($urandom_range(0, 31) == 0);
      tick();
    end
    byte_valid = 0; byte_err = 0; flag_clr = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
